// File: rtl/seq_divider_16b_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the 4-bit carry-lookahead slice used by the trial subtractor.
package seq_divider_16b_pkg;

   localparam int N_DEF = 16;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_RUN_ENC  = 2'd1;
   localparam logic [1:0] ST_FIX_ENC  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_RUN  = ST_RUN_ENC,
      ST_FIX  = ST_FIX_ENC
   } state_t;

   // Iteration counter must hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

   // Returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

endpackage

// File: rtl/seq_divider_16b_if.sv
// Request/response bundle between the execute-stage control and the divider.
interface seq_divider_16b_if #(parameter int N = 16);
   logic         start;
   logic         signed_op;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_16b_step.sv
// Combinational trial subtract T = R_shifted - D on cascaded 4-bit CLA slices
// (A + ~D + 1); no_borrow is the carry out of the (N+1)-bit chain.
module seq_divider_16b_step
   import seq_divider_16b_pkg::*;
#(
   parameter int N = N_DEF
)
(
   input  logic [N:0]   r_shift,
   input  logic [N-1:0] d,
   output logic [N-1:0] t,
   output logic         no_borrow
);

   localparam int W  = N + 1;
   localparam int NS = (W + 3) / 4;
   localparam int WP = NS * 4;

   logic [WP-1:0] a_p;
   logic [WP-1:0] bn_p;
   logic [WP-1:0] s_p;
   logic [NS:0]   c;
   logic          unused_hi;

   assign a_p  = WP'(r_shift);
   assign bn_p = ~(WP'(d));
   assign c[0] = 1'b1;

   for (genvar i = 0; i < NS; i++) begin : g_slice
      assign {c[i+1], s_p[4*i +: 4]} = cla4(a_p[4*i +: 4], bn_p[4*i +: 4], c[i]);
   end

   // Only the low N bits are ever kept: a restored remainder is always below D.
   assign t         = s_p[N-1:0];
   assign no_borrow = c[NS];
   assign unused_hi = ^s_p[WP-1:N];

endmodule

// File: rtl/seq_divider_16b.sv
// Multi-cycle restoring divider (DIV/DIVU): one quotient bit per cycle,
// sign fix-up at the end, results held until the next accepted start.
//
//  state | meaning
//  IDLE  | waiting for start; outputs hold the last result
//  RUN   | N shift/trial-subtract iterations, then load the sign-fixed results
//  FIX   | results valid, done pulses for this one cycle
module seq_divider_16b
   import seq_divider_16b_pkg::*;
#(
   parameter int N = N_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   seq_divider_16b_if.slave bus
);

   localparam int CW = cnt_width(N);

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  r_q;
   logic [N-1:0]  q_q;
   logic [N-1:0]  d_q;
   logic          qs_q;
   logic          rs_q;
   logic [N-1:0]  quot_q;
   logic [N-1:0]  rem_q;
   logic          dbz_q;

   logic          busy;
   logic          done;
   logic          accept;
   logic          last_iter;
   logic          div_zero;
   logic          dvd_neg;
   logic          dvs_neg;
   logic [N-1:0]  dvd_abs;
   logic [N-1:0]  dvs_abs;
   logic [N:0]    trial_a;
   logic [N-1:0]  trial_t;
   logic          no_borrow;

   assign div_zero = (bus.divisor == '0);
   assign dvd_neg  = bus.signed_op & bus.dividend[N-1];
   assign dvs_neg  = bus.signed_op & bus.divisor[N-1];
   // -2^(N-1) negates to itself, which is exactly its unsigned magnitude.
   assign dvd_abs  = dvd_neg ? -bus.dividend : bus.dividend;
   assign dvs_abs  = dvs_neg ? -bus.divisor  : bus.divisor;

   assign trial_a  = {r_q, q_q[N-1]};

   seq_divider_16b_step #(.N(N)) u_step (
      .r_shift   (trial_a),
      .d         (d_q),
      .t         (trial_t),
      .no_borrow (no_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      last_iter = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = div_zero ? ST_FIX : ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               last_iter = 1'b1;
               state_d   = ST_FIX;
            end
         end
         ST_FIX: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         r_q    <= '0;
         q_q    <= '0;
         d_q    <= '0;
         qs_q   <= 1'b0;
         rs_q   <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else if (accept) begin
         cnt_q <= CW'(N);
         r_q   <= '0;
         q_q   <= dvd_abs;
         d_q   <= dvs_abs;
         qs_q  <= dvd_neg ^ dvs_neg;
         rs_q  <= dvd_neg;
         if (div_zero) begin
            quot_q <= '1;
            rem_q  <= bus.dividend;
            dbz_q  <= 1'b1;
         end
      end else if (last_iter) begin
         quot_q <= qs_q ? -q_q : q_q;
         rem_q  <= rs_q ? -r_q : r_q;
         dbz_q  <= 1'b0;
      end else if (state_q == ST_RUN) begin
         cnt_q <= cnt_q - CW'(1);
         q_q   <= {q_q[N-2:0], no_borrow};
         r_q   <= no_borrow ? trial_t : trial_a[N-1:0];
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16b.sv
// Scoreboard bench for seq_divider_16b: directed vectors push expectations,
// a negedge monitor pops and compares whenever done is seen.
module tb_seq_divider_16b;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          lat;
      int          issue;
      string       name;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   logic prev_done;
   exp_t sb[$];

   seq_divider_16b_if #(.N(16)) bus ();

   seq_divider_16b #(.N(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done) begin
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            chk("busy_with_done", {31'd0, bus.busy}, 32'd1);
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_q"}, {16'd0, bus.quotient}, {16'd0, e.q});
               chk({e.name, "_r"}, {16'd0, bus.remainder}, {16'd0, e.r});
               chk({e.name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
               chk({e.name, "_lat"}, cyc - e.issue, e.lat);
            end
         end
         prev_done = bus.done;
      end
   end

   // noisy: keep start high with different operands while busy and through the done cycle
   task automatic run_op(input string nm, input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                         input logic noisy);
      logic seen;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.signed_op = s;
      bus.dividend  = a;
      bus.divisor   = b;
      sb.push_back('{q: eq, r: er, dbz: edbz, lat: (b == 16'd0) ? 1 : 18, issue: cyc, name: nm});
      @(negedge clk);
      bus.start     = noisy;
      bus.signed_op = ~s;
      bus.dividend  = a ^ 16'h5a5a;
      bus.divisor   = 16'h0003;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) chk({nm, "_timeout"}, 32'd1, 32'd0);
      if (noisy) begin
         @(posedge clk);
         #1 bus.start = 1'b0;
      end
      @(negedge clk);
      chk({nm, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = 16'h0000;
      bus.divisor   = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_q", {16'd0, bus.quotient}, 32'd0);
      chk("rst_r", {16'd0, bus.remainder}, 32'd0);
      chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      rst_n = 1'b1;

      run_op("divu_100_7",     1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0);
      run_op("div_m7_2",       1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
      run_op("div_7_m2",       1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
      run_op("divu_dbz",       1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
      run_op("div_ovf",        1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0);
      run_op("divu_8000_ffff", 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0);
      run_op("divu_ffff_1",    1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      run_op("divu_5_9",       1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 1'b0);
      run_op("div_min_2",      1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b0);
      run_op("div_m1_m1",      1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
      run_op("div_100_m7",     1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
      run_op("div_m100_7",     1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
      run_op("divu_ffff_ff",   1'b0, 16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 1'b0, 1'b0);
      run_op("divu_0_5",       1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0);
      run_op("divu_noisy",     1'b0, 16'd1000, 16'd33,   16'd30,   16'd10,   1'b0, 1'b1);
      run_op("div_dbz_noisy",  1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
      run_op("divu_after",     1'b0, 16'd50,   16'd6,    16'd8,    16'd2,    1'b0, 1'b0);

      // Abort at iteration 8; previous outputs are all nonzero so clearing is visible.
      run_op("div_dbz_pre",    1'b1, 16'hABCD, 16'h0000, 16'hFFFF, 16'hABCD, 1'b1, 1'b0);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.signed_op = 1'b0;
      bus.dividend  = 16'd999;
      bus.divisor   = 16'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_q", {16'd0, bus.quotient}, 32'd0);
      chk("abort_r", {16'd0, bus.remainder}, 32'd0);
      chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      run_op("divu_post_rst",  1'b0, 16'd999,  16'd10,   16'd99,   16'd9,    1'b0, 1'b0);

      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
